// File: rtl/vga_vram_pkg.sv
// Shared VRAM definitions: visible pixel count, write command record, write FSM states.
// Also imported by the read-pixel controller for the pixel count.
package vga_vram_pkg;

  localparam logic [19:0] PL_VRAM_PIXEL_NUM = 20'h4B000;

  typedef struct packed {
    logic        fill;
    logic [19:0] addr;
    logic [15:0] data;
    logic [19:0] len;
  } write_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_GAP
  } write_state_t;

  // Number of words that fall inside the visible frame starting at addr.
  function automatic logic [19:0] clip_len(input logic [19:0] addr, input logic [19:0] len);
    logic [19:0] room;
    room = PL_VRAM_PIXEL_NUM - addr;
    if (addr >= PL_VRAM_PIXEL_NUM) clip_len = 20'd0;
    else if (len < room)           clip_len = len;
    else                           clip_len = room;
  endfunction

endpackage

// File: rtl/vga_vram_write_cmd_fifo.sv
// Purpose: synchronous FIFO of write commands with flush and registered full/empty.
// Latency: a pushed entry is poppable the cycle after the push.
// Backpressure: push ignored while full; pop ignored while empty; flush wins over both.
module vga_vram_write_cmd_fifo
  import vga_vram_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DEPTH_N = 4
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               flush,
  input  logic               push,
  input  write_cmd_t         push_cmd,
  input  logic               pop,
  output write_cmd_t         pop_cmd,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_N:0]   count
);

  localparam logic [DEPTH_N:0] FULL_CNT = (DEPTH_N+1)'(DEPTH);

  write_cmd_t         mem [DEPTH];
  logic [DEPTH_N-1:0] wr_ptr;
  logic [DEPTH_N-1:0] rd_ptr;
  logic [DEPTH_N:0]   count_nxt;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (!do_push && do_pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (do_push) mem[wr_ptr] <= push_cmd;
  end

  assign pop_cmd = mem[rd_ptr];

endmodule

// File: rtl/vga_vram_control_write_pixel.sv
// Purpose: queue pixel/fill commands and issue clipped 16-bit VRAM writes in bursts of BLOCK_LEN.
// Latency: first write request 3 cycles after the command is accepted.
// Backpressure: oCMD_BUSY while the queue is full; iMEM_BUSY stalls the current write in place.
module vga_vram_control_write_pixel
  import vga_vram_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_DEPTH_N = 4,
  parameter int BLOCK_LEN    = 8
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iCMD_REQ,
  output logic        oCMD_BUSY,
  input  logic        iCMD_FILL,
  input  logic [19:0] iCMD_ADDR,
  input  logic [15:0] iCMD_DATA,
  input  logic [19:0] iCMD_LENGTH,
  output logic        oMEM_WRITESTATE,
  output logic        oMEM_REQ,
  output logic [19:0] oMEM_ADDR,
  output logic [15:0] oMEM_DATA,
  input  logic        iMEM_BUSY,
  output logic        oOP_DONE,
  output logic        oCMD_CLIP,
  output logic        oIDLE
);

  localparam logic [3:0] BLK_LAST = 4'(BLOCK_LEN - 1);

  write_state_t          state, state_nxt;
  write_cmd_t            push_cmd, head_cmd, ld_cmd;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_DEPTH_N:0] fifo_count;
  logic [19:0]           ld_len, ld_remain;
  logic [19:0]           cur_addr, cur_remain;
  logic [15:0]           cur_data;
  logic [3:0]            blk_cnt;
  logic                  mem_acc, done_q;

  assign push_cmd = '{fill: iCMD_FILL, addr: iCMD_ADDR, data: iCMD_DATA, len: iCMD_LENGTH};

  vga_vram_write_cmd_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .DEPTH_N (FIFO_DEPTH_N)
  ) u_fifo (
    .iCLOCK   (iCLOCK),
    .inRESET  (inRESET),
    .flush    (iRESET_SYNC),
    .push     (iCMD_REQ),
    .push_cmd (push_cmd),
    .pop      (fifo_pop),
    .pop_cmd  (head_cmd),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // A single-pixel command always writes exactly one word.
  assign ld_len    = ld_cmd.fill ? ld_cmd.len : 20'd1;
  assign ld_remain = clip_len(ld_cmd.addr, ld_len);
  assign mem_acc   = (state == ST_WRITE) && !iMEM_BUSY;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)         state <= ST_IDLE;
    else if (iRESET_SYNC) state <= ST_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    fifo_pop        = 1'b0;
    oMEM_REQ        = 1'b0;
    oMEM_WRITESTATE = 1'b0;
    oCMD_CLIP       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        oCMD_CLIP = (ld_remain < ld_len);
        state_nxt = (ld_remain == 20'd0) ? ST_IDLE : ST_WRITE;
      end
      ST_WRITE: begin
        oMEM_REQ        = 1'b1;
        oMEM_WRITESTATE = 1'b1;
        if (mem_acc && ((cur_remain == 20'd1) || (blk_cnt == BLK_LAST))) state_nxt = ST_GAP;
      end
      ST_GAP: state_nxt = (cur_remain != 20'd0) ? ST_WRITE : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ld_cmd     <= '0;
      cur_addr   <= '0;
      cur_data   <= '0;
      cur_remain <= '0;
      blk_cnt    <= '0;
      done_q     <= 1'b0;
    end else if (iRESET_SYNC) begin
      ld_cmd     <= '0;
      cur_addr   <= '0;
      cur_data   <= '0;
      cur_remain <= '0;
      blk_cnt    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fifo_pop) ld_cmd <= head_cmd;
      case (state)
        ST_LOAD: begin
          cur_addr   <= ld_cmd.addr;
          cur_data   <= ld_cmd.data;
          cur_remain <= ld_remain;
          blk_cnt    <= 4'd0;
          done_q     <= (ld_remain == 20'd0);
        end
        ST_WRITE: begin
          if (mem_acc) begin
            cur_addr   <= cur_addr + 20'd1;
            cur_remain <= cur_remain - 20'd1;
            blk_cnt    <= blk_cnt + 4'd1;
            done_q     <= (cur_remain == 20'd1);
          end
        end
        ST_GAP:  blk_cnt <= 4'd0;
        default: ;
      endcase
    end
  end

  assign oMEM_ADDR = cur_addr;
  assign oMEM_DATA = cur_data;
  assign oOP_DONE  = done_q;
  assign oCMD_BUSY = fifo_full;
  assign oIDLE     = (state == ST_IDLE) && (fifo_count == '0);

endmodule

// File: tb/tb_vga_vram_control_write_pixel.sv
// Directed and randomized bench for the VRAM write controller; expected writes, block sizes
// and done/clip pulse counts come from a frame-clipping model of each accepted command.
module tb_vga_vram_control_write_pixel;

  localparam int PIX = 'h4B000;
  localparam int BLK = 8;

  logic        iCLOCK, inRESET, iRESET_SYNC;
  logic        iCMD_REQ, oCMD_BUSY, iCMD_FILL;
  logic [19:0] iCMD_ADDR, iCMD_LENGTH, oMEM_ADDR;
  logic [15:0] iCMD_DATA, oMEM_DATA;
  logic        oMEM_WRITESTATE, oMEM_REQ, iMEM_BUSY, oOP_DONE, oCMD_CLIP, oIDLE;

  vga_vram_control_write_pixel dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iCMD_REQ(iCMD_REQ), .oCMD_BUSY(oCMD_BUSY), .iCMD_FILL(iCMD_FILL),
    .iCMD_ADDR(iCMD_ADDR), .iCMD_DATA(iCMD_DATA), .iCMD_LENGTH(iCMD_LENGTH),
    .oMEM_WRITESTATE(oMEM_WRITESTATE), .oMEM_REQ(oMEM_REQ), .oMEM_ADDR(oMEM_ADDR),
    .oMEM_DATA(oMEM_DATA), .iMEM_BUSY(iMEM_BUSY), .oOP_DONE(oOP_DONE),
    .oCMD_CLIP(oCMD_CLIP), .oIDLE(oIDLE)
  );

  int checks = 0, failures = 0;
  int busy_mode = 0;
  int obs_addr[$], obs_data[$], obs_blk[$], exp_addr[$], exp_data[$], exp_blk[$];
  int obs_done = 0, obs_clip = 0, exp_done = 0, exp_clip = 0, blk_run = 0, ws_bad = 0;

  initial begin
    iCLOCK = 1'b0;
    forever #5 iCLOCK = ~iCLOCK;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  // Bus observer: a write is counted when the arbiter will take it at the next edge.
  initial forever begin
    @(negedge iCLOCK);
    if (inRESET) begin
      if (oMEM_WRITESTATE !== oMEM_REQ) ws_bad++;
      if (oMEM_REQ === 1'b1) begin
        if (iMEM_BUSY === 1'b0) begin
          obs_addr.push_back(int'(oMEM_ADDR));
          obs_data.push_back(int'(oMEM_DATA));
          blk_run++;
        end
      end else if (blk_run > 0) begin
        obs_blk.push_back(blk_run);
        blk_run = 0;
      end
      if (oOP_DONE === 1'b1)  obs_done++;
      if (oCMD_CLIP === 1'b1) obs_clip++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
    case (busy_mode)
      0:       iMEM_BUSY = 1'b0;
      1:       iMEM_BUSY = 1'b1;
      2:       iMEM_BUSY = ($urandom_range(0, 3) == 0);
      default: iMEM_BUSY = ~iMEM_BUSY;
    endcase
  endtask

  task automatic model_cmd(input bit fill, input int addr, input int data, input int len);
    int l, n;
    l = fill ? len : 1;
    if (addr >= PIX)     n = 0;
    else if (PIX - addr < l) n = PIX - addr;
    else                 n = l;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(addr + i);
      exp_data.push_back(data & 'hFFFF);
    end
    for (int r = n; r > 0; r -= BLK) exp_blk.push_back(r > BLK ? BLK : r);
    exp_done++;
    if (n < l) exp_clip++;
  endtask

  task automatic drive(input bit fill, input int addr, input int data, input int len);
    iCMD_REQ = 1'b1; iCMD_FILL = fill;
    iCMD_ADDR = 20'(addr); iCMD_DATA = 16'(data); iCMD_LENGTH = 20'(len);
  endtask

  task automatic push(input bit fill, input int addr, input int data, input int len);
    int k = 0;
    while (oCMD_BUSY && k < 1000) begin tick(); k++; end
    chkb("push_wait_busy", oCMD_BUSY, 1'b0);
    drive(fill, addr, data, len);
    model_cmd(fill, addr, data, len);
    tick();
    iCMD_REQ = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    tick(); tick();
    while (!oIDLE && k < 3000) begin tick(); k++; end
    chkb($sformatf("%s_idle", tag), oIDLE, 1'b1);
    tick(); tick();
  endtask

  task automatic compare(input string tag);
    chk($sformatf("%s_nwrites", tag), obs_addr.size(), exp_addr.size());
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
      chk($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
    end
    chk($sformatf("%s_nblocks", tag), obs_blk.size(), exp_blk.size());
    for (int i = 0; i < obs_blk.size() && i < exp_blk.size(); i++)
      chk($sformatf("%s_blk%0d", tag, i), obs_blk[i], exp_blk[i]);
    chk($sformatf("%s_done", tag), obs_done, exp_done);
    chk($sformatf("%s_clip", tag), obs_clip, exp_clip);
    chk($sformatf("%s_writestate", tag), ws_bad, 0);
    obs_addr.delete(); obs_data.delete(); obs_blk.delete();
    exp_addr.delete(); exp_data.delete(); exp_blk.delete();
    obs_done = 0; obs_clip = 0; exp_done = 0; exp_clip = 0; ws_bad = 0;
  endtask

  initial begin
    int acc, k, base;
    inRESET = 1'b0; iRESET_SYNC = 1'b0; iCMD_REQ = 1'b0; iCMD_FILL = 1'b0;
    iCMD_ADDR = '0; iCMD_DATA = '0; iCMD_LENGTH = '0; iMEM_BUSY = 1'b0;
    tick(); tick(); tick();
    chkb("rst_req", oMEM_REQ, 1'b0);
    chkb("rst_ws", oMEM_WRITESTATE, 1'b0);
    chk("rst_addr", int'(oMEM_ADDR), 0);
    chk("rst_data", int'(oMEM_DATA), 0);
    chkb("rst_done", oOP_DONE, 1'b0);
    chkb("rst_clip", oCMD_CLIP, 1'b0);
    chkb("rst_busy", oCMD_BUSY, 1'b0);
    chkb("rst_idle", oIDLE, 1'b1);
    inRESET = 1'b1;
    tick(); tick();

    // Single pixel: write at N+3, done at N+4, idle at N+5; length field is ignored.
    drive(1'b0, 'h00123, 'hF800, 77);
    model_cmd(1'b0, 'h00123, 'hF800, 77);
    for (int n = 1; n <= 5; n++) begin
      tick();
      iCMD_REQ = 1'b0;
      chkb($sformatf("lat_req_n%0d", n), oMEM_REQ, n == 3);
      chkb($sformatf("lat_done_n%0d", n), oOP_DONE, n == 4);
      chkb($sformatf("lat_idle_n%0d", n), oIDLE, n == 5);
      if (n == 3) begin
        chk("lat_addr", int'(oMEM_ADDR), 'h00123);
        chk("lat_data", int'(oMEM_DATA), 'hF800);
      end
    end
    wait_idle("lat");
    compare("lat");

    push(1'b1, 'h00100, $urandom_range(0, 'hFFFF), 20);
    wait_idle("fill20");
    compare("fill20");

    // Fill crossing the end of the frame: clip reported during LOAD (N+2).
    drive(1'b1, 'h4AFFE, 'h1234, 5);
    model_cmd(1'b1, 'h4AFFE, 'h1234, 5);
    for (int n = 1; n <= 3; n++) begin
      tick();
      iCMD_REQ = 1'b0;
      chkb($sformatf("clip_pulse_n%0d", n), oCMD_CLIP, n == 2);
    end
    wait_idle("clip");
    compare("clip");

    push(1'b0, 'h4B000, 'h00FF, 0);
    push(1'b1, 'h00300, 'h0F0F, 0);
    wait_idle("zero");
    compare("zero");

    busy_mode = 1;
    tick();
    acc = 0;
    for (int a = 0; a < 18; a++) begin
      drive(1'b0, 'h01000 + a * 3, a, 1);
      if (!oCMD_BUSY) begin
        model_cmd(1'b0, 'h01000 + a * 3, a, 1);
        acc++;
      end
      tick();
    end
    iCMD_REQ = 1'b0;
    chkb("full_busy", oCMD_BUSY, 1'b1);
    chkb("full_reject", acc < 18, 1'b1);
    busy_mode = 0;
    wait_idle("full");
    chkb("full_busy_clear", oCMD_BUSY, 1'b0);
    compare("full");

    busy_mode = 2;
    for (int c = 0; c < 16; c++) begin
      int sel, addr;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       addr = $urandom_range(0, PIX - 1);
        1:       addr = PIX - $urandom_range(1, 12);
        2:       addr = $urandom_range(PIX, 'hFFFFF);
        default: addr = $urandom_range(0, 64);
      endcase
      push(1'($urandom_range(0, 1)), addr, $urandom_range(0, 'hFFFF), $urandom_range(0, 30));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    wait_idle("rand");
    compare("rand");

    // Sync clear in mid-block: exactly 30 writes land, the queued single is discarded.
    busy_mode = 3;
    base = 'h02000;
    push(1'b1, base, 'hABCD, 100);
    push(1'b0, 'h00050, 'h5555, 1);
    exp_addr.delete(); exp_data.delete(); exp_blk.delete();
    exp_done = 0; exp_clip = 0;
    for (int i = 0; i < 30; i++) begin
      exp_addr.push_back(base + i);
      exp_data.push_back('hABCD);
    end
    exp_blk.push_back(8); exp_blk.push_back(8); exp_blk.push_back(8); exp_blk.push_back(6);
    k = 0;
    while (obs_addr.size() < 30 && k < 2000) begin tick(); k++; end
    chk("sync_reach30", obs_addr.size(), 30);
    iMEM_BUSY = 1'b1;
    iRESET_SYNC = 1'b1;
    tick();
    iRESET_SYNC = 1'b0;
    busy_mode = 0;
    iMEM_BUSY = 1'b0;
    chkb("sync_req_drop", oMEM_REQ, 1'b0);
    chkb("sync_idle_now", oIDLE, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    chkb("sync_idle_later", oIDLE, 1'b1);
    compare("sync");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
